// File: rtl/pwm_dac_tx.sv
// PWM DAC transmitter: W-bit codes arrive through a valid/ready FIFO and are
// rendered as a fixed-period PWM waveform, with duty switched only at period boundaries.
module pwm_dac_tx #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [W-1:0]               period_val,
    input  logic [W-1:0]               code_i,
    input  logic                       code_valid_i,
    output logic                       code_ready_o,
    output logic                       pwm_o,
    output logic                       period_strb_o,
    output logic                       underrun_o,
    input  logic                       underrun_clr_i,
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic [W-1:0]               active_code_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  ZERO_W   = {W{1'b0}};
    localparam logic [AW-1:0] ONE_A    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] ONE_L    = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] ZERO_L   = {LW{1'b0}};
    localparam logic [LW-1:0] FULL_L   = LW'(DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state_r;
    logic [W-1:0]   cnt_r;
    logic [W-1:0]   duty_r;
    logic [W-1:0]   per_lat_r;
    logic           pwm_r;
    logic           strb_r;
    logic           underrun_r;
    logic [W-1:0]   mem_r [DEPTH];
    logic [AW-1:0]  rd_ptr_r;
    logic [AW-1:0]  wr_ptr_r;
    logic [LW-1:0]  level_r;
    logic           ready_r;

    logic           go_s;
    logic           boundary_s;
    logic           load_s;
    logic           stop_s;
    logic           empty_s;
    logic           push_s;
    logic           pop_s;
    logic [W-1:0]   cnt_next_s;
    logic [W-1:0]   duty_next_s;
    logic           cmp_s;
    logic [LW-1:0]  level_next_s;

    assign go_s       = ena && (period_val != ZERO_W);
    assign boundary_s = (state_r == RUN) && (cnt_r == (per_lat_r - ONE_W));
    assign load_s     = go_s && ((state_r == IDLE) || boundary_s);
    assign stop_s     = boundary_s && !go_s;
    assign empty_s    = (level_r == ZERO_L);
    assign push_s     = code_valid_i && ready_r;
    // A code pushed in a load cycle is never bypassed: pop only sees what was already stored.
    assign pop_s      = load_s && !empty_s;
    assign cmp_s      = (cnt_next_s < duty_next_s);

    // Next counter and duty, shared by the FSM and the PWM compare.
    always_comb begin
        cnt_next_s  = cnt_r;
        duty_next_s = duty_r;
        if (load_s) begin
            cnt_next_s = ZERO_W;
            if (!empty_s) begin
                duty_next_s = mem_r[rd_ptr_r];
            end else begin
                duty_next_s = duty_r;
            end
        end else if ((state_r == RUN) && !stop_s) begin
            cnt_next_s = cnt_r + ONE_W;
        end else begin
            cnt_next_s = ZERO_W;
        end
    end

    // Next FIFO occupancy.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + ONE_L;
            2'b01:   level_next_s = level_r - ONE_L;
            default: level_next_s = level_r;
        endcase
    end

    // Period FSM with registered PWM and strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= ZERO_W;
            duty_r    <= ZERO_W;
            per_lat_r <= ZERO_W;
            pwm_r     <= 1'b0;
            strb_r    <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            duty_r <= duty_next_s;
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        state_r   <= RUN;
                        per_lat_r <= period_val;
                        strb_r    <= 1'b1;
                        pwm_r     <= cmp_s;
                    end else begin
                        strb_r    <= 1'b0;
                        pwm_r     <= 1'b0;
                    end
                end
                RUN: begin
                    if (load_s) begin
                        per_lat_r <= period_val;
                        strb_r    <= 1'b1;
                        pwm_r     <= cmp_s;
                    end else if (stop_s) begin
                        state_r   <= IDLE;
                        strb_r    <= 1'b0;
                        pwm_r     <= 1'b0;
                    end else begin
                        strb_r    <= 1'b0;
                        pwm_r     <= cmp_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    strb_r  <= 1'b0;
                    pwm_r   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underrun flag; a new underrun wins over a clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_r <= 1'b0;
        end else if (load_s && empty_s) begin
            underrun_r <= 1'b1;
        end else if (underrun_clr_i) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            level_r  <= ZERO_L;
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_A;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_A;
            end
            level_r <= level_next_s;
            ready_r <= (level_next_s != FULL_L);
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= code_i;
        end
    end

    assign code_ready_o  = ready_r;
    assign pwm_o         = pwm_r;
    assign period_strb_o = strb_r;
    assign underrun_o    = underrun_r;
    assign fifo_level_o  = level_r;
    assign active_code_o = duty_r;

endmodule

// File: tb/tb_pwm_dac_tx.sv
// Scoreboard bench for pwm_dac_tx: a period-level reference model predicts every
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_pwm_dac_tx;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic [W-1:0]  period_val;
    logic [W-1:0]  code_i;
    logic          code_valid_i;
    logic          code_ready_o;
    logic          pwm_o;
    logic          period_strb_o;
    logic          underrun_o;
    logic          underrun_clr_i;
    logic [2:0]    fifo_level_o;
    logic [W-1:0]  active_code_o;

    int checks   = 0;
    int failures = 0;

    pwm_dac_tx #(.W(W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .period_val     (period_val),
        .code_i         (code_i),
        .code_valid_i   (code_valid_i),
        .code_ready_o   (code_ready_o),
        .pwm_o          (pwm_o),
        .period_strb_o  (period_strb_o),
        .underrun_o     (underrun_o),
        .underrun_clr_i (underrun_clr_i),
        .fifo_level_o   (fifo_level_o),
        .active_code_o  (active_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit pwm;
        bit strb;
        int code;
        int lvl;
        bit under;
    } exp_t;

    exp_t expq[$];
    int   mq[$];
    bit   m_run;
    int   m_i, m_p, m_d;
    bit   m_u;
    bit   m_push, m_go, m_setu;
    exp_t m_e;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a period is P cycles of (index < duty), started from the code queue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            expq.delete();
            m_run = 1'b0; m_i = 0; m_p = 0; m_d = 0; m_u = 1'b0;
        end else begin
            m_push = code_valid_i && (mq.size() < DEPTH);
            m_go   = ena && (period_val != 0);
            m_setu = 1'b0;
            if (!m_run || (m_i == m_p - 1)) begin
                if (m_go) begin
                    m_run = 1'b1;
                    m_p   = int'(period_val);
                    m_i   = 0;
                    if (mq.size() > 0) m_d = mq.pop_front();
                    else m_setu = 1'b1;
                end else begin
                    m_run = 1'b0;
                    m_i   = 0;
                end
            end else begin
                m_i++;
            end
            if (m_setu) m_u = 1'b1;
            else if (underrun_clr_i) m_u = 1'b0;
            if (m_push) mq.push_back(int'(code_i));
            m_e.pwm   = m_run && (m_i < m_d);
            m_e.strb  = m_run && (m_i == 0);
            m_e.code  = m_d;
            m_e.lvl   = mq.size();
            m_e.under = m_u;
            expq.push_back(m_e);
        end
    end

    // Monitor: compare DUT outputs once per cycle against the predicted entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_pwm", int'(pwm_o), 0);
            chk("rst_strb", int'(period_strb_o), 0);
            chk("rst_level", int'(fifo_level_o), 0);
            chk("rst_ready", int'(code_ready_o), 1);
            chk("rst_code", int'(active_code_o), 0);
            chk("rst_underrun", int'(underrun_o), 0);
        end else if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("pwm", int'(pwm_o), int'(e.pwm));
            chk("strb", int'(period_strb_o), int'(e.strb));
            chk("active_code", int'(active_code_o), e.code);
            chk("level", int'(fifo_level_o), e.lvl);
            chk("ready", int'(code_ready_o), int'(e.lvl != DEPTH));
            chk("underrun", int'(underrun_o), int'(e.under));
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(int c);
        code_i       = W'(c);
        code_valid_i = 1'b1;
        tick();
        code_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; period_val = '0; code_i = '0;
        code_valid_i = 1'b0; underrun_clr_i = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Basic, period 4
        period_val = 16'd4;
        push(1); push(2);
        chk("basic_level", int'(fifo_level_o), 2);
        ena = 1'b1;
        tick(16);
        ena = 1'b0;
        tick(6);
        underrun_clr_i = 1'b1; tick(); underrun_clr_i = 1'b0;
        tick(2);
        chk("clr_underrun", int'(underrun_o), 0);

        // Limits, period 5
        period_val = 16'd5;
        push(0); push(5); push(9);
        ena = 1'b1;
        tick(20);
        ena = 1'b0;
        tick(6);

        // FIFO full and backpressure
        push(3); push(1); push(2); push(3);
        chk("full_level", int'(fifo_level_o), 4);
        chk("full_ready", int'(code_ready_o), 0);
        push(7);
        chk("full_hold", int'(fifo_level_o), 4);
        period_val = 16'd3;
        ena = 1'b1;
        tick();
        chk("after_load_level", int'(fifo_level_o), 3);
        chk("after_load_ready", int'(code_ready_o), 1);
        for (int k = 0; k < 12; k++) begin
            code_i = W'(k % 4); code_valid_i = (k % 2 == 0); tick();
        end
        code_valid_i = 1'b0;
        tick(10);
        code_i = 16'd2; code_valid_i = 1'b1; tick(); code_valid_i = 1'b0;
        tick(8);

        // Mid-period period change and ena drop
        period_val = 16'd8;
        ena = 1'b0; tick(4);
        push(4); push(6);
        ena = 1'b1; tick(3);
        period_val = 16'd3;
        tick(14);
        ena = 1'b0;
        tick(12);

        // Period of one cycle
        period_val = 16'd1; push(1); ena = 1'b1; tick(6); ena = 1'b0; tick(3);

        // Asynchronous reset at cnt=3 with two codes queued
        push(5); push(6); push(7);
        period_val = 16'd8; ena = 1'b1;
        tick(4);
        chk("pre_rst_level", int'(fifo_level_o), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pwm", int'(pwm_o), 0);
        chk("async_strb", int'(period_strb_o), 0);
        chk("async_level", int'(fifo_level_o), 0);
        chk("async_ready", int'(code_ready_o), 1);
        chk("async_code", int'(active_code_o), 0);
        ena = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Randomized traffic
        period_val = 16'd4;
        for (int k = 0; k < 3000; k++) begin
            code_valid_i   = ($urandom_range(0, 9) < 4);
            code_i         = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 65535))
                                                         : W'($urandom_range(0, 7));
            underrun_clr_i = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 19) == 0) period_val = W'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) ena = ~ena;
            tick();
        end
        code_valid_i = 1'b0; underrun_clr_i = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
